router_pkt_fifo: RTL and testbench

Parametrised packet-aware FIFO for the 1x3 router output channels. It is the next generation of the fixed 9-bit, 16-deep router FIFO, with configurable width and depth. Each stored word is tagged as a header or a non-header word. On the read side it tracks packet boundaries from the header length field, and it reports occupancy, almost-full and sticky overflow/underflow status. One instance sits between the router FSM/register block and each output port.

---
 rtl/router_pkt_fifo.sv | 163 ++++++++++++++++
 tb/tb_router_pkt_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO for the 1x3 router: header-tagged storage,
// packet-boundary tracking on the read side, occupancy and sticky error status.
module router_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_W      = 6,
  parameter int AF_THRESH  = DEPTH - 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      soft_reset,
  input  logic                      we,
  input  logic                      re,
  input  logic                      lfd_state,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_out_valid,
  output logic                      header_out,
  output logic                      pkt_done,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    AF_CNT   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0]    ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0]  ONE_PTR  = AW'(1);
  localparam logic [LEN_W:0] ONE_REM  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] ZERO_REM = (LEN_W+1)'(0);

  logic [DATA_WIDTH:0]   mem_r [DEPTH];
  logic [AW-1:0]         wp_r;
  logic [AW-1:0]         rp_r;
  logic [AW:0]           count_r;
  logic [LEN_W:0]        rem_r;
  logic                  lfd_d_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  header_out_r;
  logic                  valid_r;
  logic                  pkt_done_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic [DATA_WIDTH:0]   rd_word_s;
  logic                  rd_tag_s;
  logic [LEN_W-1:0]      rd_len_s;
  logic [LEN_W:0]        rem_nxt_s;
  logic                  pkt_done_nxt_s;
  logic [AW:0]           count_nxt_s;

  // Flag decode, accept qualification and next-state for count and packet tracking.
  always_comb begin
    full_s         = (count_r == FULL_CNT);
    empty_s        = (count_r == (AW+1)'(0));
    wr_ok_s        = we && !full_s;
    rd_ok_s        = re && !empty_s;
    rd_word_s      = mem_r[rp_r];
    rd_tag_s       = rd_word_s[DATA_WIDTH];
    rd_len_s       = rd_word_s[DATA_WIDTH-1 -: LEN_W];
    rem_nxt_s      = rem_r;
    pkt_done_nxt_s = 1'b0;
    count_nxt_s    = count_r;

    // rem holds len+1 after a header so the parity word lands on rem == 1
    if (!rd_ok_s) begin
      rem_nxt_s = rem_r;
    end else if (rd_tag_s) begin
      rem_nxt_s = {1'b0, rd_len_s} + ONE_REM;
    end else if (rem_r != ZERO_REM) begin
      rem_nxt_s = rem_r - ONE_REM;
    end else begin
      rem_nxt_s = rem_r;
    end

    if (rd_ok_s && !rd_tag_s && (rem_r == ONE_REM)) begin
      pkt_done_nxt_s = 1'b1;
    end else begin
      pkt_done_nxt_s = 1'b0;
    end

    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + ONE_CNT;
      2'b01:   count_nxt_s = count_r - ONE_CNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; deliberately never cleared by either reset.
  always_ff @(posedge clock) begin
    if (wr_ok_s && !soft_reset && !reset) begin
      mem_r[wp_r] <= {lfd_d_r, data_in};
    end
  end

  // Pointers, occupancy, packet tracking, registered read port and sticky status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_r         <= '0;
      rp_r         <= '0;
      count_r      <= '0;
      rem_r        <= '0;
      lfd_d_r      <= 1'b0;
      data_out_r   <= '0;
      header_out_r <= 1'b0;
      valid_r      <= 1'b0;
      pkt_done_r   <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else if (soft_reset) begin
      wp_r         <= '0;
      rp_r         <= '0;
      count_r      <= '0;
      rem_r        <= '0;
      lfd_d_r      <= 1'b0;
      data_out_r   <= '0;
      header_out_r <= 1'b0;
      valid_r      <= 1'b0;
      pkt_done_r   <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      lfd_d_r    <= lfd_state;
      count_r    <= count_nxt_s;
      rem_r      <= rem_nxt_s;
      valid_r    <= rd_ok_s;
      pkt_done_r <= pkt_done_nxt_s;
      if (wr_ok_s) begin
        wp_r <= wp_r + ONE_PTR;
      end
      if (rd_ok_s) begin
        rp_r                       <= rp_r + ONE_PTR;
        {header_out_r, data_out_r} <= rd_word_s;
      end
      if (we && full_s) begin
        overflow_r <= 1'b1;
      end
      if (re && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign data_out       = data_out_r;
  assign header_out     = header_out_r;
  assign data_out_valid = valid_r;
  assign pkt_done       = pkt_done_r;
  assign full           = full_s;
  assign empty          = empty_s;
  assign almost_full    = (count_r >= AF_CNT);
  assign count          = count_r;
  assign overflow       = overflow_r;
  assign underflow      = underflow_r;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: stimulus queues expected read words,
// a negedge monitor pops and compares every data_out_valid pulse.
module tb_router_pkt_fifo;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       we;
  logic       re;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       header_out;
  logic       pkt_done;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  logic [8:0] model_q [$];   // {tag, data} of words believed stored
  logic [9:0] exp_q   [$];   // {pkt_done, header_out, data_out} expected per read
  logic       lfd_prev = 1'b0;

  router_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(16), .LEN_W(6), .AF_THRESH(14)) dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset),
    .we(we), .re(re), .lfd_state(lfd_state), .data_in(data_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .header_out(header_out), .pkt_done(pkt_done),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // monitor: every read pulse must match the head of the scoreboard queue
  always @(negedge clock) begin
    if (data_out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%0h exp=none", {pkt_done, header_out, data_out});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({pkt_done, header_out, data_out} !== e) begin
          failures++;
          $display("FAIL rd_word got=%0h exp=%0h", {pkt_done, header_out, data_out}, e);
        end
      end
    end
  end

  // one clock of stimulus; pd_exp is the hand-derived pkt_done for this read
  task automatic cycle(input logic w, input logic r, input logic [7:0] d,
                       input logic lfd, input logic pd_exp);
    we = w; re = r; data_in = d; lfd_state = lfd;
    if (r && model_q.size() > 0) begin
      exp_q.push_back({pd_exp, model_q[0]});
      void'(model_q.pop_front());
    end
    if (w && model_q.size() < 16) model_q.push_back({lfd_prev, d});
    lfd_prev = lfd;
    @(posedge clock); #1;
    we = 1'b0; re = 1'b0; lfd_state = 1'b0;
  endtask

  logic [7:0] par;

  initial begin
    reset = 1'b1; soft_reset = 1'b0; we = 1'b0; re = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // packet: header len=14, 14 payload words, parity
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    par = 8'h39;
    cycle(1'b1, 1'b0, 8'h39, 1'b0, 1'b0);
    chk("af_1", 32'(almost_full), 32'd0);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
      par = par ^ (8'h10 + 8'(i));
      if (i == 11) chk("af_13", 32'(almost_full), 32'd0);
      if (i == 12) chk("af_14", 32'(almost_full), 32'd1);
    end
    chk("full_15", 32'(full), 32'd0);
    cycle(1'b1, 1'b0, par, 1'b0, 1'b0);
    chk("full_16", 32'(full), 32'd1);
    chk("count_16", 32'(count), 32'd16);
    chk("ovf_before", 32'(overflow), 32'd0);

    // 17th write while full is dropped
    cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("count_ovf", 32'(count), 32'd16);

    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, (i == 15) ? 1'b1 : 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // read while empty: underflow, data_out holds last word
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("udf_set", 32'(underflow), 32'd1);
    chk("udf_hold", 32'(data_out), 32'(par));
    chk("udf_novalid", 32'(data_out_valid), 32'd0);

    // steady state at count 5 with pointer wrap; orphan words never finish a packet
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      if (i == 9) chk("rw_count_mid", 32'(count), 32'd5);
    end
    chk("rw_count", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("rw_empty", 32'(empty), 32'd1);

    // packet len=10 (11 words), read 2, flush at count 9 with a read pending
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 8'h28, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd9);
    soft_reset = 1'b1; re = 1'b1;
    @(posedge clock); #1;
    soft_reset = 1'b0; re = 1'b0;
    model_q.delete();
    lfd_prev = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_udf", 32'(underflow), 32'd0);
    chk("flush_valid", 32'(data_out_valid), 32'd0);
    chk("flush_dout", 32'(data_out), 32'd0);

    // new packet len=3; header write coincides with a read while empty
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
    chk("we_re_empty_count", 32'(count), 32'd1);
    chk("we_re_empty_udf", 32'(underflow), 32'd1);
    cycle(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hA3, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hAC, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, (i == 4) ? 1'b1 : 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pkt2_empty", 32'(empty), 32'd1);

    // asynchronous reset mid-cycle acts without a clock edge
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_dout", 32'(data_out), 32'd0);
    model_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
